reg_file: RTL and testbench

//   Single-port-write / single-port-read register file, 2**ADDR_WIDTH x DATA_WIDTH.

---
 rtl/reg_file_pkg.sv | 12 +
 rtl/reg_file_mem.sv | 37 +++
 rtl/reg_file.sv | 54 +++++
 tb/tb_reg_file.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the reg_file register-file slice.
package reg_file_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 8;
  localparam bit RF_RST_VAL    = '0;

  function automatic int rf_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/reg_file_mem.sv
// Storage array of reg_file: synchronous write port, asynchronous clear, and a
// combinational read tap that the top level registers.
module reg_file_mem
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_a,
  input  logic [DATA_WIDTH-1:0] wr_d,
  input  logic [ADDR_WIDTH-1:0] rd_a,
  output logic [DATA_WIDTH-1:0] rd_q
);

  localparam int DEPTH = rf_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  // NOTE: the array is deliberately cleared on reset, since every entry must
  // read back 0 after rst; this rules out mapping onto a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {DATA_WIDTH{RF_RST_VAL}};
      end
    end else if (wr_en) begin
      mem[wr_a] <= wr_d;
    end
  end

  assign rd_q = mem[rd_a];

endmodule

// File: rtl/reg_file.sv
// reg_file top: storage plus registered read port (1-cycle latency).
// Define REG_FILE_BYPASS_EN for write-first forwarding on same-address rd/wr;
// the default build is read-first.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] wr_a,
  input  logic [ADDR_WIDTH-1:0] rd_a,
  input  logic [DATA_WIDTH-1:0] wr_d,
  output logic [DATA_WIDTH-1:0] rd_d
);

  logic [DATA_WIDTH-1:0] mem_q;
  logic [DATA_WIDTH-1:0] rd_next;

  reg_file_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .wr_en(wr_en),
    .wr_a (wr_a),
    .wr_d (wr_d),
    .rd_a (rd_a),
    .rd_q (mem_q)
  );

  // NOTE: default assigned first so the mux can never infer a latch.
  always_comb begin
    rd_next = mem_q;
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && (wr_a == rd_a)) begin
      rd_next = wr_d;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_d <= {DATA_WIDTH{RF_RST_VAL}};
    end else if (rd_en) begin
      rd_d <= rd_next;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: shadow-memory model feeding a scoreboard
// queue of expected rd_d values, compared one cycle after each drive.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] wr_a = '0;
  logic [AW-1:0] rd_a = '0;
  logic [DW-1:0] wr_d = '0;
  logic [DW-1:0] rd_d;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_rd;
  logic [DW-1:0] exp_q [$];
  string         tag_q [$];

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .wr_a (wr_a),
    .rd_a (rd_a),
    .wr_d (wr_d),
    .rd_d (rd_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_rd = '0;
  endtask

  // Drive one cycle at negedge, predict rd_d, then compare just after the edge.
  task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra, input string tag);
    logic [DW-1:0] e;
    string         t;
    @(negedge clk);
    wr_en = we; wr_a = wa; wr_d = wd; rd_en = re; rd_a = ra;
    e = exp_rd;
    if (re) begin
      e = model[ra];
`ifdef REG_FILE_BYPASS_EN
      if (we && (wa == ra)) e = wd;
`endif
    end
    exp_rd = e;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (we) model[wa] = wd;
    @(posedge clk);
    #1;
    t = tag_q.pop_front();
    check(t, rd_d, exp_q.pop_front());
  endtask

  initial begin
    clear_model();

    // Reset held 5 clocks with both ports active: nothing may leak through.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_en = 1'b1; rd_en = 1'b1; wr_a = 8'd0; rd_a = 8'd0; wr_d = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      check("rd_d_in_reset", rd_d, '0);
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    rst = 1'b1;

    cycle(1'b0, 8'd0, '0, 1'b1, 8'd0, "rst_rd0");

    cycle(1'b1, 8'd100, 32'h1010_0010, 1'b0, 8'd0, "wr100_hold");
    cycle(1'b0, 8'd0, '0, 1'b1, 8'd100, "rd100");

    cycle(1'b1, 8'd3, 32'hA102_FFFF, 1'b0, 8'd7, "wr3_hold");
    cycle(1'b1, 8'd0, 32'hA102_FFFF, 1'b0, 8'd9, "wr0_hold");
    cycle(1'b0, 8'd0, '0, 1'b0, 8'd200, "rd_off_hold_a");
    cycle(1'b0, 8'd0, '0, 1'b0, 8'd3, "rd_off_hold_b");
    cycle(1'b0, 8'd0, '0, 1'b1, 8'd3, "rd3");
    cycle(1'b0, 8'd0, '0, 1'b1, 8'd0, "rd0");

    cycle(1'b0, 8'd6, 32'hA945_FCBF, 1'b0, 8'd0, "wr6_disabled");
    cycle(1'b0, 8'd0, '0, 1'b1, 8'd6, "rd6");

    cycle(1'b1, 8'd111, 32'h0BAD_F00D, 1'b0, 8'd0, "wr111_old");
    cycle(1'b1, 8'd111, 32'h5555_FFFF, 1'b1, 8'd111, "same_addr_rw");
    cycle(1'b0, 8'd0, '0, 1'b1, 8'd111, "same_addr_next");

    cycle(1'b1, 8'd255, 32'hFFFF_0001, 1'b1, 8'd254, "diff_addr_rw");
    cycle(1'b0, 8'd0, '0, 1'b1, 8'd255, "rd255");

    // Random traffic over a narrow window to force frequent address collisions.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), DW'($urandom()),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), "random");
    end

    // Fill some entries, then clear asynchronously in the middle of a write.
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 8'(i * 7), DW'($urandom()) | 32'h1, 1'b1, 8'(i * 7), "prefill");
    end
    @(negedge clk);
    wr_en = 1'b1; wr_a = 8'd14; wr_d = 32'hCAFE_F00D; rd_en = 1'b1; rd_a = 8'd14;
    #2;
    rst = 1'b0;
    #1;
    check("async_clr_rd_d", rd_d, '0);
    clear_model();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rd_d_held_clear", rd_d, '0);
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 8'd0, '0, 1'b1, 8'(i), "post_clr_rd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
